text_line_renderer: RTL and testbench

Fetch-side master for the 8x8 font ROM: renders one scanline of a text line as a serial 1-bit pixel stream. It reads character codes from a synchronous text buffer, drives the font ROM's character/row inputs, captures each 8-bit glyph row and shifts it out MSB-first under a valid/ready handshake. It sits between the text buffer and the display pixel mux in the overlay path.

---
 rtl/text_render_pkg.sv | 17 +
 rtl/glyph_shifter.sv | 44 ++++
 rtl/text_line_renderer.sv | 139 +++++++++++++
 tb/tb_text_line_renderer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_render_pkg.sv
// Shared constants and FSM encoding for the text overlay fetch path.
// Glyphs are 8x8 cells addressed by a 7-bit character code.
package text_render_pkg;

  localparam int GLYPH_W         = 8;
  localparam int GLYPH_H         = 8;
  localparam int CHAR_W          = 7;
  localparam int ROW_W           = $clog2(GLYPH_H);
  localparam int TEXT_ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/glyph_shifter.sv
// 8-bit parallel-in serial-out pixel shifter, MSB (leftmost pixel) first,
// with a valid/ready output side and empty/last-bit flags for the fetch logic.
module glyph_shifter
  import text_render_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [GLYPH_W-1:0] load_data,
  input  logic               ready,
  output logic               valid,
  output logic               data,
  output logic               empty,
  output logic               last
);

  localparam int CNT_W = $clog2(GLYPH_W + 1);

  logic [GLYPH_W-1:0] sreg;
  logic [CNT_W-1:0]   remaining;

  assign valid = (remaining != '0);
  assign data  = sreg[GLYPH_W-1];
  assign empty = !valid;
  assign last  = (remaining == CNT_W'(1));

  // Load wins over shift: the parent only loads when empty or when the last
  // bit is leaving this very cycle, so nothing is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      remaining <= '0;
    end else if (load) begin
      // NOTE: non-blocking everywhere in clocked logic so every register
      // here updates from the same pre-edge values.
      sreg      <= load_data;
      remaining <= CNT_W'(GLYPH_W);
    end else if (valid && ready) begin
      sreg      <= {sreg[GLYPH_W-2:0], 1'b0};
      remaining <= remaining - CNT_W'(1);
    end
  end

endmodule

// File: rtl/text_line_renderer.sv
// Renders one scanline of a text line: fetches character codes, looks up the
// glyph row in the font ROM and streams it out as 1-bit pixels.
module text_line_renderer
  import text_render_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int TEXT_ADDR_W = TEXT_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   line_start,
  input  logic [TEXT_ADDR_W-1:0] text_base,
  input  logic [ROW_W-1:0]       text_row,
  output logic                   busy,
  output logic [TEXT_ADDR_W-1:0] char_addr,
  input  logic [CHAR_W-1:0]      char_data,
  output logic [CHAR_W-1:0]      font_char,
  output logic [ROW_W-1:0]       font_row,
  input  logic [GLYPH_W-1:0]     font_data,
  output logic                   pix_valid,
  output logic                   pix_data,
  input  logic                   pix_ready,
  output logic                   line_done
);

  localparam int IDX_W = $clog2(COLS + 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               req_addr;
  logic               req_data;
  logic [GLYPH_W-1:0] gbuf;
  logic               gbuf_valid;

  logic               sh_load;
  logic [GLYPH_W-1:0] sh_load_data;
  logic               sh_empty;
  logic               sh_last;

  logic xfer, last_xfer, chars_left, in_flight, issue;
  logic cap_to_sh, cap_to_buf, reload, line_end;

  assign font_char = char_data;

  // A fetch occupies two stages: address presented (req_addr), then data
  // returned from the synchronous text buffer and font ROM (req_data).
  assign xfer       = pix_valid && pix_ready;
  assign last_xfer  = sh_last && xfer;
  assign chars_left = (idx != IDX_W'(COLS));
  assign in_flight  = req_addr || req_data;
  assign issue      = (state == ST_RUN) && chars_left && !in_flight
                      && (!gbuf_valid || last_xfer);

  assign cap_to_sh  = req_data && (sh_empty || last_xfer);
  assign cap_to_buf = req_data && !cap_to_sh;
  assign reload     = last_xfer && gbuf_valid;

  assign sh_load      = reload || cap_to_sh;
  assign sh_load_data = reload ? gbuf : font_data;

  assign line_end = (state == ST_RUN) && !chars_left && !in_flight
                    && !gbuf_valid && last_xfer;

  glyph_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_data (sh_load_data),
    .ready     (pix_ready),
    .valid     (pix_valid),
    .data      (pix_data),
    .empty     (sh_empty),
    .last      (sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      line_done <= 1'b0;
      char_addr <= '0;
      font_row  <= '0;
      idx       <= '0;
      req_addr  <= 1'b0;
      req_data  <= 1'b0;
    end else begin
      line_done <= 1'b0;
      req_addr  <= 1'b0;
      req_data  <= req_addr;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          // The start pulse itself issues the fetch for character 0.
          if (line_start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            char_addr <= text_base;
            font_row  <= text_row;
            idx       <= IDX_W'(1);
            req_addr  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue) begin
            char_addr <= char_addr + TEXT_ADDR_W'(1);
            idx       <= idx + IDX_W'(1);
            req_addr  <= 1'b1;
          end
          if (line_end) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            line_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Glyph buffer holds the next row while the shifter drains the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this data register is reset along with its valid flag so an
      // aborted line leaves no stale glyph behind.
      gbuf       <= '0;
      gbuf_valid <= 1'b0;
    end else if (cap_to_buf) begin
      gbuf       <= font_data;
      gbuf_valid <= 1'b1;
    end else if (reload) begin
      gbuf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_text_line_renderer.sv
// Bench for text_line_renderer (COLS=2): text buffer and font ROM models,
// random contents, expected pixel streams from a line-level reference model.
module tb_text_line_renderer;

  localparam int COLS = 2;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_start = 1'b0;
  logic [AW-1:0] text_base = '0;
  logic [2:0]    text_row = '0;
  logic          busy;
  logic [AW-1:0] char_addr;
  logic [6:0]    char_data = '0;
  logic [6:0]    font_char;
  logic [2:0]    font_row;
  logic [7:0]    font_data;
  logic          pix_valid;
  logic          pix_data;
  logic          pix_ready = 1'b1;
  logic          line_done;

  logic [6:0] tmem [64];
  logic [7:0] rom  [128][8];

  int checks = 0;
  int failures = 0;

  // Results of the most recent run_line
  logic [15:0]   got_bits;
  int            got_n;
  logic [AW-1:0] addr_seen [4];
  int            n_addr;
  int            first_lat, bubbles, valid_cycles, stall_err, done_gap;
  bit            done_seen, done_busy, done_valid, busy_at0;
  logic [AW-1:0] addr_at0;
  logic [2:0]    row_at0;

  text_line_renderer #(.COLS(COLS), .TEXT_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .text_base  (text_base),
    .text_row   (text_row),
    .busy       (busy),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .font_char  (font_char),
    .font_row   (font_row),
    .font_data  (font_data),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .line_done  (line_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) char_data <= tmem[char_addr];
  assign font_data = rom[font_char][font_row];

  // Reference: the scanline is the concatenation of each character's glyph row.
  function automatic logic [15:0] model_line(input logic [AW-1:0] base, input logic [2:0] row);
    logic [15:0] r;
    logic [AW-1:0] a;
    r = '0;
    for (int c = 0; c < COLS; c++) begin
      a = base + AW'(c);
      r = (r << 8) | 16'(rom[tmem[a]][row]);
    end
    return r;
  endfunction

  // mode 0: ready always high; mode 1: 5-cycle stall at pixel 3 then random.
  task automatic run_line(input logic [AW-1:0] base, input logic [2:0] row, input int mode,
                          input int ovl_at, input bit prestarted, input bit chain,
                          input logic [AW-1:0] nbase, input logic [2:0] nrow);
    int cnt, last_push, stall_left;
    bit prev_stall, stalled_once;
    logic prev_data;
    got_bits = '0; got_n = 0; n_addr = 0; first_lat = -1; bubbles = 0;
    valid_cycles = 0; stall_err = 0; done_gap = -1; done_seen = 0;
    done_busy = 1; done_valid = 1; prev_stall = 0; prev_data = 0;
    stalled_once = 0; stall_left = 0; last_push = -100;
    if (!prestarted) begin
      @(negedge clk);
      line_start = 1'b1; text_base = base; text_row = row; pix_ready = 1'b1;
    end
    @(negedge clk);
    line_start = 1'b0; text_base = AW'($urandom); text_row = 3'($urandom);
    busy_at0 = busy; addr_at0 = char_addr; row_at0 = font_row;
    cnt = 0;
    while (cnt < 400) begin
      if (line_done) begin
        done_seen = 1; done_gap = cnt - last_push;
        done_busy = busy; done_valid = pix_valid;
        break;
      end
      if (busy && n_addr < 4 && (n_addr == 0 || addr_seen[n_addr-1] != char_addr)) begin
        addr_seen[n_addr] = char_addr;
        n_addr++;
      end
      if (prev_stall && (!pix_valid || pix_data !== prev_data)) stall_err++;
      if (pix_valid) begin
        valid_cycles++;
        if (first_lat < 0) first_lat = cnt;
      end else if (first_lat >= 0) bubbles++;
      line_start = (cnt == ovl_at);
      text_base  = ~base;
      if (stall_left > 0) begin
        pix_ready = 1'b0; stall_left--;
      end else if (mode == 1 && !stalled_once && got_n == 3 && pix_valid) begin
        stalled_once = 1; stall_left = 4; pix_ready = 1'b0;
      end else begin
        pix_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      if (pix_valid && pix_ready) begin
        got_bits = {got_bits[14:0], pix_data}; got_n++; last_push = cnt;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      @(negedge clk);
      cnt++;
    end
    pix_ready = 1'b1;
    if (chain && done_seen) begin
      line_start = 1'b1; text_base = nbase; text_row = nrow;
    end else begin
      line_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      line_start = 1'($urandom); text_base = AW'($urandom);
      text_row = 3'($urandom); pix_ready = 1'($urandom);
      checks++;
      if ({busy, line_done, pix_valid, pix_data} !== 4'b0) begin
        failures++;
        $display("FAIL reset_flags: got %b want 0000", {busy, line_done, pix_valid, pix_data});
      end
    end
    checks++;
    if (char_addr !== '0 || font_row !== '0) begin
      failures++;
      $display("FAIL reset_regs: char_addr=%0h font_row=%0h want 0", char_addr, font_row);
    end
    @(negedge clk);
    line_start = 1'b0; pix_ready = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%b pix_valid=%b want 0", busy, pix_valid);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    tmem[6'h10] = 7'h41; tmem[6'h11] = 7'h42;
    rom[7'h41][3] = 8'hA5; rom[7'h42][3] = 8'h3C;
    exp = model_line(6'h10, 3'd3);
    run_line(6'h10, 3'd3, 0, -1, 0, 0, '0, '0);
    checks++;
    if (busy_at0 !== 1'b1 || addr_at0 !== 6'h10 || row_at0 !== 3'd3) begin
      failures++;
      $display("FAIL basic_e0: busy=%b addr=%0h row=%0d want 1 10 3", busy_at0, addr_at0, row_at0);
    end
    checks++;
    if (n_addr != 2 || addr_seen[0] !== 6'h10 || addr_seen[1] !== 6'h11) begin
      failures++;
      $display("FAIL basic_addr: n=%0d a0=%0h a1=%0h want 2 10 11", n_addr, addr_seen[0], addr_seen[1]);
    end
    checks++;
    if (first_lat != 2) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 2", first_lat);
    end
    checks++;
    if (got_n != 16 || got_bits !== 16'hA53C || got_bits !== exp) begin
      failures++;
      $display("FAIL basic_pixels: n=%0d bits=%h want 16 a53c", got_n, got_bits);
    end
    checks++;
    if (bubbles != 0 || valid_cycles != 16) begin
      failures++;
      $display("FAIL basic_gapless: bubbles=%0d valid_cycles=%0d want 0 16", bubbles, valid_cycles);
    end
    checks++;
    if (!done_seen || done_gap != 1 || done_busy !== 1'b0 || done_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: seen=%b gap=%0d busy=%b valid=%b want 1 1 0 0",
               done_seen, done_gap, done_busy, done_valid);
    end
    @(negedge clk);
    checks++;
    if (line_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: line_done=%b busy=%b want 0 0", line_done, busy);
    end
  endtask

  task automatic test_backpressure();
    run_line(6'h10, 3'd3, 1, -1, 0, 0, '0, '0);
    checks++;
    if (got_n != 16 || got_bits !== 16'hA53C) begin
      failures++;
      $display("FAIL bp_pixels: n=%0d bits=%h want 16 a53c", got_n, got_bits);
    end
    checks++;
    if (stall_err != 0) begin
      failures++;
      $display("FAIL bp_stable: unstable_stall_cycles=%0d want 0", stall_err);
    end
    checks++;
    if (!done_seen || done_gap != 1 || done_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: seen=%b gap=%0d valid=%b want 1 1 0", done_seen, done_gap, done_valid);
    end
  endtask

  task automatic test_random_lines();
    logic [AW-1:0] b;
    logic [2:0] r;
    int m;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 64; i++) tmem[i] = 7'($urandom);
      b = AW'($urandom); r = 3'($urandom); m = int'($urandom_range(0, 1));
      run_line(b, r, m, -1, 0, 0, '0, '0);
      checks++;
      if (got_n != 16 || got_bits !== model_line(b, r) || stall_err != 0 || !done_seen) begin
        failures++;
        $display("FAIL random_line%0d: n=%0d bits=%h want %h stall_err=%0d done=%b",
                 it, got_n, got_bits, model_line(b, r), stall_err, done_seen);
      end
    end
  endtask

  task automatic test_wrap();
    run_line(6'd63, 3'd6, 0, -1, 0, 0, '0, '0);
    checks++;
    if (n_addr != 2 || addr_seen[0] !== 6'd63 || addr_seen[1] !== 6'd0) begin
      failures++;
      $display("FAIL wrap_addr: n=%0d a0=%0d a1=%0d want 2 63 0", n_addr, addr_seen[0], addr_seen[1]);
    end
    checks++;
    if (got_n != 16 || got_bits !== model_line(6'd63, 3'd6)) begin
      failures++;
      $display("FAIL wrap_pixels: n=%0d bits=%h want %h", got_n, got_bits, model_line(6'd63, 3'd6));
    end
  endtask

  task automatic test_overlap();
    run_line(6'd5, 3'd2, 0, 6, 0, 1, 6'd20, 3'd5);
    checks++;
    if (got_n != 16 || got_bits !== model_line(6'd5, 3'd2) || n_addr != 2 || addr_seen[1] !== 6'd6) begin
      failures++;
      $display("FAIL overlap_ignored: n=%0d bits=%h want %h naddr=%0d",
               got_n, got_bits, model_line(6'd5, 3'd2), n_addr);
    end
    run_line(6'd20, 3'd5, 0, -1, 1, 0, '0, '0);
    checks++;
    if (busy_at0 !== 1'b1 || addr_at0 !== 6'd20 || row_at0 !== 3'd5 || first_lat != 2) begin
      failures++;
      $display("FAIL overlap_restart: busy=%b addr=%0d row=%0d lat=%0d want 1 20 5 2",
               busy_at0, addr_at0, row_at0, first_lat);
    end
    checks++;
    if (got_n != 16 || got_bits !== model_line(6'd20, 3'd5) || !done_seen) begin
      failures++;
      $display("FAIL overlap_pixels: n=%0d bits=%h want %h", got_n, got_bits, model_line(6'd20, 3'd5));
    end
  endtask

  task automatic test_reset_mid();
    int n, guard;
    bit spurious;
    @(negedge clk);
    line_start = 1'b1; text_base = 6'd40; text_row = 3'd1; pix_ready = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    n = 0; guard = 0;
    while (n < 5 && guard < 50) begin
      if (pix_valid) n++;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL midreset_progress: pixels=%0d want 5", n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, pix_valid, pix_data, line_done, char_addr, font_row} !== '0) begin
      failures++;
      $display("FAIL midreset_async: busy=%b valid=%b data=%b done=%b addr=%0h row=%0d want all 0",
               busy, pix_valid, pix_data, line_done, char_addr, font_row);
    end
    spurious = 0;
    repeat (2) begin
      @(negedge clk);
      if (line_done || busy) spurious = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (line_done || busy) spurious = 1;
    end
    checks++;
    if (spurious) begin
      failures++;
      $display("FAIL midreset_no_done: line_done or busy seen after abort, want none");
    end
    run_line(6'd40, 3'd1, 0, -1, 0, 0, '0, '0);
    checks++;
    if (got_n != 16 || got_bits !== model_line(6'd40, 3'd1) || addr_at0 !== 6'd40 || !done_seen) begin
      failures++;
      $display("FAIL midreset_rerun: n=%0d bits=%h want %h addr0=%0d",
               got_n, got_bits, model_line(6'd40, 3'd1), addr_at0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tmem[i] = 7'($urandom);
    for (int c = 0; c < 128; c++)
      for (int r = 0; r < 8; r++) rom[c][r] = 8'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_random_lines();
    test_wrap();
    test_overlap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
